// File: rtl/sme_pkg.sv
// Shared constants and state encodings for the String Machine Engine
// (loader front end and comparator).
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 10;
    localparam int STR_W   = (STR_MAX + 2) * 8;
    localparam int PAT_W   = PAT_MAX * 8;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] HEAD  = 8'h5E;
    localparam logic [7:0] TAIL  = 8'h24;
    localparam logic [7:0] DOT   = 8'h2E;

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_LD_STR = 3'd1,
        C_LD_PAT = 3'd2,
        C_COMP   = 3'd3,
        C_OUT    = 3'd4
    } c_state_t;

endpackage

// File: rtl/sme_str_packer.sv
// Packs serial string characters into the sentinel-framed string vector:
// leading SPACE at the top used byte, trailing SPACE at byte 0.
module sme_str_packer
    import sme_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_first,
    input  logic             load_next,
    input  logic [7:0]       chardata,
    output logic [STR_W-1:0] str_vec,
    output logic [5:0]       str_len
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_vec <= '0;
            str_len <= '0;
        end else if (load_first) begin
            str_vec <= {{(STR_W - 24){1'b0}}, SPACE, chardata, SPACE};
            str_len <= 6'd1;
        end else if (load_next && (str_len < 6'(STR_MAX))) begin
            // Byte 33 is only non-zero once the string is full, so dropping it is safe.
            str_vec <= {str_vec[STR_W-9:8], chardata, SPACE};
            str_len <= str_len + 6'd1;
        end
    end

endmodule

// File: rtl/sme_loader.sv
// SME front end: sequences string/pattern loading, drives the comparator
// through c_state and returns the corrected match result.
//
// state  | meaning
// IDLE   | waiting for the first string or pattern char
// LD_STR | collecting string chars
// LD_PAT | collecting pattern chars; a gap starts the compare
// COMP   | vectors frozen, waiting for the comparator ready pulse
// OUT    | one-cycle valid strobe with the latched result
module sme_loader
    import sme_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             isstring,
    input  logic             ispattern,
    input  logic [7:0]       chardata,
    output logic [STR_W-1:0] str_reg_w,
    output logic [PAT_W-1:0] pat_reg_w,
    output logic [5:0]       str_len,
    output logic [3:0]       pat_len,
    output logic [2:0]       c_state,
    input  logic             ready_i,
    input  logic             match_i,
    input  logic [4:0]       match_index_i,
    output logic             match,
    output logic [4:0]       match_index,
    output logic             valid,
    output logic             busy
);

    c_state_t   state, next_state;
    logic       str_first, str_next, pat_first, pat_add, take_result;
    logic [3:0] pat_slot;
    logic [4:0] idx_adj;

    sme_str_packer u_str_packer (
        .clk        (clk),
        .reset      (reset),
        .load_first (str_first),
        .load_next  (str_next),
        .chardata   (chardata),
        .str_vec    (str_reg_w),
        .str_len    (str_len)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= C_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        str_first   = 1'b0;
        str_next    = 1'b0;
        pat_first   = 1'b0;
        pat_add     = 1'b0;
        take_result = 1'b0;
        case (state)
            C_IDLE: begin
                if (isstring) begin
                    str_first  = 1'b1;
                    next_state = C_LD_STR;
                end else if (ispattern) begin
                    pat_first  = 1'b1;
                    next_state = C_LD_PAT;
                end
            end
            C_LD_STR: begin
                if (isstring) begin
                    str_next = 1'b1;
                end else if (ispattern) begin
                    pat_first  = 1'b1;
                    next_state = C_LD_PAT;
                end
            end
            C_LD_PAT: begin
                if (isstring) begin
                    str_first  = 1'b1;
                    next_state = C_LD_STR;
                end else if (ispattern) begin
                    pat_add = 1'b1;
                end else begin
                    next_state = C_COMP;
                end
            end
            C_COMP: begin
                if (ready_i) begin
                    take_result = 1'b1;
                    next_state  = C_OUT;
                end
            end
            C_OUT:   next_state = C_IDLE;
            default: next_state = C_IDLE;
        endcase
    end

    assign c_state  = state;
    assign pat_slot = 4'(PAT_MAX - 1) - pat_len;

    // An anchored pattern ('^' first) carries one fewer leading sentinel offset.
    assign idx_adj = match_index_i - ((pat_reg_w[PAT_W-1 -: 8] == HEAD) ? 5'd1 : 5'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg_w <= '0;
            pat_len   <= '0;
        end else if (pat_first) begin
            pat_reg_w <= {chardata, {(PAT_W - 8){1'b0}}};
            pat_len   <= 4'd1;
        end else if (pat_add && (pat_len < 4'(PAT_MAX))) begin
            pat_reg_w[{pat_slot, 3'b000} +: 8] <= chardata;
            pat_len                            <= pat_len + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match       <= 1'b0;
            match_index <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= take_result;
            busy  <= (next_state == C_COMP) || (next_state == C_OUT);
            if (take_result) begin
                match       <= match_i;
                match_index <= match_i ? idx_adj : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_sme_loader.sv
// Directed self-checking bench for sme_loader with a hand-driven comparator.
module tb_sme_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         isstring, ispattern;
    logic [7:0]   chardata;
    logic [271:0] str_reg_w;
    logic [79:0]  pat_reg_w;
    logic [5:0]   str_len;
    logic [3:0]   pat_len;
    logic [2:0]   c_state;
    logic         ready_i, match_i;
    logic [4:0]   match_index_i;
    logic         match, valid, busy;
    logic [4:0]   match_index;

    int checks = 0;
    int errors = 0;

    logic [271:0] exp_str;
    logic [79:0]  exp_pat;
    string        long_str, long_pat;

    sme_loader dut (
        .clk           (clk),
        .reset         (reset),
        .isstring      (isstring),
        .ispattern     (ispattern),
        .chardata      (chardata),
        .str_reg_w     (str_reg_w),
        .pat_reg_w     (pat_reg_w),
        .str_len       (str_len),
        .pat_len       (pat_len),
        .c_state       (c_state),
        .ready_i       (ready_i),
        .match_i       (match_i),
        .match_index_i (match_index_i),
        .match         (match),
        .match_index   (match_index),
        .valid         (valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            isstring = 1'b1;
            chardata = s[i];
            tick();
        end
        isstring = 1'b0;
    endtask

    task automatic send_pat(input string s);
        for (int i = 0; i < s.len(); i++) begin
            ispattern = 1'b1;
            chardata  = s[i];
            tick();
        end
        ispattern = 1'b0;
    endtask

    task automatic wait_comp(input string tag);
        int n = 0;
        while (c_state !== 3'd3 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_comp"}, c_state, 3'd3);
    endtask

    // Comparator pulse, then check the OUT cycle and the return to IDLE.
    task automatic run_comp(input string tag, input logic m, input logic [4:0] raw,
                            input logic exp_m, input logic [4:0] exp_idx);
        wait_comp(tag);
        ready_i = 1'b1; match_i = m; match_index_i = raw;
        tick();
        ready_i = 1'b0; match_i = 1'b0; match_index_i = 5'd0;
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_match"}, match, exp_m);
        chk({tag, "_idx"}, match_index, exp_idx);
        chk({tag, "_out"}, c_state, 3'd4);
        tick();
        chk({tag, "_valid_end"}, valid, 1'b0);
        chk({tag, "_idle"}, c_state, 3'd0);
        chk({tag, "_idx_hold"}, match_index, exp_idx);
    endtask

    initial begin
        reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
        ready_i = 1'b0; match_i = 1'b0; match_index_i = 5'd0;
        tick(); tick();
        chk("rst_state", c_state, 3'd0);
        chk("rst_str", str_reg_w, '0);
        chk("rst_pat", pat_reg_w, '0);
        chk("rst_outs", {valid, match, match_index, busy, str_len, pat_len}, '0);
        reset = 1'b0;
        tick();

        // 1: string "ab"
        send_str("ab");
        chk("t1_str", str_reg_w, 272'h20616220);
        chk("t1_len", str_len, 6'd2);
        chk("t1_state", c_state, 3'd1);
        tick();
        chk("t1_hold", str_reg_w, 272'h20616220);

        // 2: pattern "b", raw 3 -> index 1
        send_pat("b");
        chk("t2_pat", pat_reg_w, {8'h62, 72'h0});
        chk("t2_plen", pat_len, 4'd1);
        wait_comp("t2");
        chk("t2_busy", busy, 1'b1);
        run_comp("t2", 1'b1, 5'd3, 1'b1, 5'd1);

        // 3: anchored pattern, then a new pattern reusing the string
        send_str("ab");
        send_pat("^a");
        chk("t3_pat", pat_reg_w, {8'h5E, 8'h61, 64'h0});
        run_comp("t3a", 1'b1, 5'd1, 1'b1, 5'd0);
        send_pat("zz");
        chk("t3_pat2", pat_reg_w, {8'h7A, 8'h7A, 64'h0});
        run_comp("t3b", 1'b0, 5'd7, 1'b0, 5'd0);
        chk("t3_str_kept", str_reg_w, 272'h20616220);

        // 4: overflow of both vectors
        long_str = "abcdefghijklmnopqrstuvwxyz01234567";
        send_str(long_str);
        exp_str = '0;
        exp_str[8*33 +: 8] = 8'h20;
        for (int i = 0; i < 32; i++) exp_str[8*(32-i) +: 8] = long_str[i];
        exp_str[7:0] = 8'h20;
        chk("t4_str", str_reg_w, exp_str);
        chk("t4_len", str_len, 6'd32);
        long_pat = "abcdefghijkl";
        send_pat(long_pat);
        exp_pat = '0;
        for (int i = 0; i < 10; i++) exp_pat[8*(9-i) +: 8] = long_pat[i];
        chk("t4_pat", pat_reg_w, exp_pat);
        chk("t4_plen", pat_len, 4'd10);

        // 5: strobes ignored during COMP; index wraps (0 - 2 = 30)
        wait_comp("t5");
        for (int i = 0; i < 4; i++) begin
            isstring = i[0]; chardata = 8'h41 + 8'(i);
            tick();
            chk("t5_str_stable", str_reg_w, exp_str);
            chk("t5_state", c_state, 3'd3);
        end
        isstring = 1'b0;
        chk("t5_pat_stable", pat_reg_w, exp_pat);
        run_comp("t5", 1'b1, 5'd0, 1'b1, 5'd30);

        // 6: reset during COMP, then a clean reload
        send_str("ab");
        send_pat("b");
        wait_comp("t6");
        reset = 1'b1;
        #1;
        chk("t6_rst_state", c_state, 3'd0);
        chk("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_str", str_reg_w, '0);
        chk("t6_rst_pat", pat_reg_w, '0);
        chk("t6_rst_lens", {str_len, pat_len}, '0);
        tick();
        reset = 1'b0;
        tick();
        send_str("xy");
        chk("t6_str", str_reg_w, 272'h20787920);
        send_pat("^x");
        run_comp("t6", 1'b1, 5'd2, 1'b1, 5'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
